// File: rtl/fetch_decode_buffer.sv
// Two-entry skid FIFO between fetch and decode; the head word is also split
// into MIPS-style fields for decode.
module fetch_decode_buffer #(
  parameter bit ZEXT_LOGIC   = 1'b1,
  parameter bit NOP_ON_EMPTY = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Inst,
  input  logic [31:0] PCNext,
  input  logic        InValid,
  output logic        InReady,
  input  logic        OutReady,
  input  logic        Flush,
  output logic        OutValid,
  output logic [31:0] OutInst,
  output logic [31:0] OutPC4,
  output logic [5:0]  Opcode,
  output logic [4:0]  Rs,
  output logic [4:0]  Rt,
  output logic [4:0]  Rd,
  output logic [4:0]  Shamt,
  output logic [5:0]  Funct,
  output logic [31:0] Imm,
  output logic [31:0] JAddr,
  output logic [1:0]  Count
);

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc4;
  } entry_t;

  entry_t     mem [2];
  logic       rptr, wptr;
  logic [1:0] cnt;
  logic       push, pop;
  entry_t     head;
  logic       zext;

  // Handshake readiness depends only on registered occupancy.
  assign InReady  = (cnt != 2'd2);
  assign OutValid = (cnt != 2'd0);
  assign Count    = cnt;
  assign push     = InValid & InReady;
  assign pop      = OutValid & OutReady;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt    <= 2'd0;
      rptr   <= 1'b0;
      wptr   <= 1'b0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else if (Flush) begin
      cnt  <= 2'd0;
      rptr <= 1'b0;
      wptr <= 1'b0;
    end else begin
      if (push) begin
        mem[wptr] <= '{inst: Inst, pc4: PCNext};
        wptr      <= ~wptr;
      end
      if (pop) rptr <= ~rptr;
      case ({push, pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Empty buffer can present an all-zero word (sll $0,$0,0) to decode.
  always_comb begin
    head = mem[rptr];
    if (NOP_ON_EMPTY && cnt == 2'd0) head = '0;
  end

  assign OutInst = head.inst;
  assign OutPC4  = head.pc4;
  assign Opcode  = head.inst[31:26];
  assign Rs      = head.inst[25:21];
  assign Rt      = head.inst[20:16];
  assign Rd      = head.inst[15:11];
  assign Shamt   = head.inst[10:6];
  assign Funct   = head.inst[5:0];

  assign zext  = ZEXT_LOGIC && (Opcode == 6'h0C || Opcode == 6'h0D || Opcode == 6'h0E);
  assign Imm   = zext ? {16'b0, head.inst[15:0]} : {{16{head.inst[15]}}, head.inst[15:0]};
  assign JAddr = {head.pc4[31:28], head.inst[25:0], 2'b00};

endmodule

// File: tb/tb_fetch_decode_buffer.sv
// Randomized + directed bench for fetch_decode_buffer; a negedge monitor
// compares the DUT against a queue model of the FIFO contents.
module tb_fetch_decode_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Inst, PCNext;
  logic        InValid, OutReady, Flush;
  logic        InReady, OutValid;
  logic [31:0] OutInst, OutPC4, Imm, JAddr;
  logic [5:0]  Opcode, Funct;
  logic [4:0]  Rs, Rt, Rd, Shamt;
  logic [1:0]  Count;

  // second copy with the alternate parameter settings, same stimulus
  logic        b_InReady, b_OutValid;
  logic [31:0] b_OutInst, b_OutPC4, b_Imm, b_JAddr;
  logic [5:0]  b_Opcode, b_Funct;
  logic [4:0]  b_Rs, b_Rt, b_Rd, b_Shamt;
  logic [1:0]  b_Count;

  int tests = 0;
  int fails = 0;
  bit mon_en = 1'b0;
  logic [63:0] q[$];

  always #5 clk = ~clk;

  fetch_decode_buffer #(.ZEXT_LOGIC(1'b1), .NOP_ON_EMPTY(1'b1)) dut (
    .clk(clk), .reset(reset), .Inst(Inst), .PCNext(PCNext), .InValid(InValid),
    .InReady(InReady), .OutReady(OutReady), .Flush(Flush), .OutValid(OutValid),
    .OutInst(OutInst), .OutPC4(OutPC4), .Opcode(Opcode), .Rs(Rs), .Rt(Rt), .Rd(Rd),
    .Shamt(Shamt), .Funct(Funct), .Imm(Imm), .JAddr(JAddr), .Count(Count));

  fetch_decode_buffer #(.ZEXT_LOGIC(1'b0), .NOP_ON_EMPTY(1'b0)) dut_b (
    .clk(clk), .reset(reset), .Inst(Inst), .PCNext(PCNext), .InValid(InValid),
    .InReady(b_InReady), .OutReady(OutReady), .Flush(Flush), .OutValid(b_OutValid),
    .OutInst(b_OutInst), .OutPC4(b_OutPC4), .Opcode(b_Opcode), .Rs(b_Rs), .Rt(b_Rt),
    .Rd(b_Rd), .Shamt(b_Shamt), .Funct(b_Funct), .Imm(b_Imm), .JAddr(b_JAddr),
    .Count(b_Count));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_imm(input logic [31:0] inst, input bit zx);
    int unsigned op, lo;
    op = inst >> 26;
    lo = inst & 32'h0000FFFF;
    if (zx && (op == 12 || op == 13 || op == 14)) return lo;
    return (lo >= 32768) ? (lo | 32'hFFFF0000) : lo;
  endfunction

  // Model: q holds {inst, pc4} of every accepted, not-yet-consumed word.
  always @(negedge clk) if (mon_en) begin
    int n;
    logic [31:0] hi, hp;
    if (reset) begin
      q.delete();
      chk("rst_count", 32'(Count), 0);
      chk("rst_outvalid", 32'(OutValid), 0);
      chk("rst_inready", 32'(InReady), 1);
      chk("rst_outinst", OutInst, 0);
      chk("rst_b_outinst", b_OutInst, 0);
    end else begin
      n = q.size();
      chk("count", 32'(Count), n);
      chk("b_count", 32'(b_Count), n);
      chk("inready", 32'(InReady), (n != 2) ? 1 : 0);
      chk("outvalid", 32'(OutValid), (n != 0) ? 1 : 0);
      if (n == 0) begin
        chk("nop_inst", OutInst, 0);
        chk("nop_pc4", OutPC4, 0);
        chk("nop_imm", Imm, 0);
        chk("nop_jaddr", JAddr, 0);
      end else begin
        hi = q[0][63:32];
        hp = q[0][31:0];
        chk("outinst", OutInst, hi);
        chk("outpc4", OutPC4, hp);
        chk("opcode", 32'(Opcode), hi / (1 << 26));
        chk("rs", 32'(Rs), (hi / (1 << 21)) % 32);
        chk("rt", 32'(Rt), (hi / (1 << 16)) % 32);
        chk("rd", 32'(Rd), (hi / (1 << 11)) % 32);
        chk("shamt", 32'(Shamt), (hi / 64) % 32);
        chk("funct", 32'(Funct), hi % 64);
        chk("imm", Imm, ref_imm(hi, 1'b1));
        chk("jaddr", JAddr, (hp & 32'hF0000000) | ((hi % (1 << 26)) * 4));
        chk("b_outinst", b_OutInst, hi);
        chk("b_imm", b_Imm, ref_imm(hi, 1'b0));
      end
      if (Flush) q.delete();
      else begin
        if (n != 0 && OutReady) void'(q.pop_front());
        if (InValid && n != 2) q.push_back({Inst, PCNext});
      end
    end
  end

  task automatic drive(input bit iv, input logic [31:0] in, input logic [31:0] pc,
                       input bit ordy, input bit fl);
    @(posedge clk);
    #1;
    InValid = iv; Inst = in; PCNext = pc; OutReady = ordy; Flush = fl;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; Inst = '0; PCNext = '0; InValid = 1'b0; OutReady = 1'b0; Flush = 1'b0;
    mon_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // single push, inspect fields, then consume
    drive(1'b1, 32'h2008000A, 32'h00000004, 1'b0, 1'b0);
    idle(1);
    #3;
    chk("addi_opcode", 32'(Opcode), 32'h08);
    chk("addi_rt", 32'(Rt), 8);
    chk("addi_imm", Imm, 32'h0000000A);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // three pushes into a stalled decode, then drain
    drive(1'b1, 32'h11111111, 32'h10, 1'b0, 1'b0);
    drive(1'b1, 32'h22222222, 32'h14, 1'b0, 1'b0);
    drive(1'b1, 32'h33333333, 32'h18, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // steady-state push+pop at occupancy 1
    drive(1'b1, 32'h99999999, 32'h20, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) drive(1'b1, 32'hAAAAAAAA + 32'(i), 32'h24 + 32'(4*i), 1'b1, 1'b0);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // flush a full buffer while fetch still presents a word
    drive(1'b1, 32'h01010101, 32'h40, 1'b0, 1'b0);
    drive(1'b1, 32'h02020202, 32'h44, 1'b0, 1'b0);
    drive(1'b1, 32'h03030303, 32'h48, 1'b0, 1'b1);
    idle(2);

    // decode corner cases
    drive(1'b1, 32'h3C0FFFFF, 32'h50, 1'b1, 1'b0);
    drive(1'b1, 32'h3508FFFF, 32'h54, 1'b1, 1'b0);
    drive(1'b1, 32'h08000010, 32'h40000004, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    #3;
    chk("j_jaddr", JAddr, 32'h40000040);
    chk("j_imm_b", b_Imm, 32'h00000010);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // async reset in the middle of a cycle with a full buffer
    drive(1'b1, 32'h0A0A0A0A, 32'h60, 1'b0, 1'b0);
    drive(1'b1, 32'h0B0B0B0B, 32'h64, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("async_outvalid", 32'(OutValid), 0);
    chk("async_count", 32'(Count), 0);
    @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    drive(1'b1, 32'h0C0C0C0C, 32'h68, 1'b0, 1'b0);
    idle(2);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // random traffic
    for (int i = 0; i < 3000; i++)
      drive(($urandom % 3) != 0, $urandom, $urandom, ($urandom % 2) == 1,
            ($urandom % 20) == 0);
    idle(3);

    @(posedge clk);
    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
